// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and timeout math for the frame receiver
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  typedef struct packed {
    logic chk;
    logic len;
    logic timeout;
    logic overrun;
  } err_t;

  // Two byte times of 10 bit periods each, in clock cycles.
  function automatic int unsigned calc_timeout(input int unsigned clk_hz,
                                               input int unsigned baud);
    return 20 * (clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload storage with one synchronous write and one registered read port
module uart_frame_buf #(
  parameter int unsigned depth = 16,
  parameter int unsigned aw    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [aw-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [aw-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] mem_q [depth];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  always_comb begin
    rd_data_d = mem_q[i_rd_addr];
  end

  // Memory contents deliberately survive reset; only the read register clears.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SYNC/LEN/payload/CHK frame parser holding one checked frame until acknowledged
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned input_clk_hz = 12_000_000,
  parameter int unsigned baud_rate    = 9600,
  parameter int unsigned max_len      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_data,
  input  logic                       i_ready,
  output logic                       o_frame_valid,
  output logic [$clog2(max_len):0]   o_frame_len,
  input  logic [$clog2(max_len)-1:0] i_rd_addr,
  output logic [7:0]                 o_rd_data,
  input  logic                       i_frame_ack,
  output logic                       o_err_chk,
  output logic                       o_err_len,
  output logic                       o_err_timeout,
  output logic                       o_err_overrun
);

  localparam int unsigned AW        = $clog2(max_len);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned TMO_LIMIT = calc_timeout(input_clk_hz, baud_rate);
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_LIMIT - 1);
  localparam logic [8:0]    MAX_LEN_9 = 9'(max_len);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;
  err_t          err_q, err_d;
  logic          valid_q, valid_d;

  logic          wr_en;
  logic          len_ok;
  logic          in_frame;
  logic [LW-1:0] idx_inc;

  assign len_ok   = (i_data != 8'd0) && ({1'b0, i_data} <= MAX_LEN_9);
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign idx_inc  = idx_q + LW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    tmo_d   = '0;
    err_d   = '0;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_ready && (i_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_ready) begin
          if (len_ok) begin
            len_d   = LW'(i_data);
            xor_d   = i_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d.len = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_ready) begin
          wr_en = 1'b1;
          xor_d = xor_q ^ i_data;
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (i_ready) begin
          if (i_data == xor_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d.chk = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // Incoming bytes are dropped while a frame is held; ack still wins.
        if (i_ready) begin
          err_d.overrun = 1'b1;
        end
        if (i_frame_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte arriving in the limit cycle takes priority over the timeout.
    if (in_frame && !i_ready) begin
      if (tmo_q == TMO_LAST) begin
        err_d.timeout = 1'b1;
        state_d       = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      xor_q   <= 8'd0;
      tmo_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  uart_frame_buf #(
    .depth (max_len),
    .aw    (AW)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (idx_q[AW-1:0]),
    .i_wr_data (i_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_frame_valid = valid_q;
  assign o_frame_len   = len_q;
  assign o_err_chk     = err_q.chk;
  assign o_err_len     = err_q.len;
  assign o_err_timeout = err_q.timeout;
  assign o_err_overrun = err_q.overrun;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized self-checking bench for uart_frame_rx
module tb_uart_frame_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int MAXL   = 16;
  localparam int LIMIT  = 20 * (CLK_HZ / BAUD);

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_ready;
  logic       o_frame_valid;
  logic [4:0] o_frame_len;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       i_frame_ack;
  logic       o_err_chk;
  logic       o_err_len;
  logic       o_err_timeout;
  logic       o_err_overrun;

  uart_frame_rx #(
    .input_clk_hz (CLK_HZ),
    .baud_rate    (BAUD),
    .max_len      (MAXL)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_ready       (i_ready),
    .o_frame_valid (o_frame_valid),
    .o_frame_len   (o_frame_len),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .i_frame_ack   (i_frame_ack),
    .o_err_chk     (o_err_chk),
    .o_err_len     (o_err_len),
    .o_err_timeout (o_err_timeout),
    .o_err_overrun (o_err_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;
  int c_chk = 0, c_len = 0, c_tmo = 0, c_ovr = 0;
  int b_chk = 0, b_len = 0, b_tmo = 0, b_ovr = 0;

  // Counts high cycles, so a pulse wider than one cycle shows up as an extra error.
  always @(negedge i_clk) begin
    c_chk += int'(o_err_chk);
    c_len += int'(o_err_len);
    c_tmo += int'(o_err_timeout);
    c_ovr += int'(o_err_overrun);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data  = b;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic check_errs(input string tag, input int e_chk, input int e_len,
                            input int e_tmo, input int e_ovr);
    check({tag, "/err_chk"},     c_chk - b_chk, e_chk);
    check({tag, "/err_len"},     c_len - b_len, e_len);
    check({tag, "/err_timeout"}, c_tmo - b_tmo, e_tmo);
    check({tag, "/err_overrun"}, c_ovr - b_ovr, e_ovr);
    b_chk = c_chk;
    b_len = c_len;
    b_tmo = c_tmo;
    b_ovr = c_ovr;
  endtask

  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] pl[$],
                            input logic [7:0] flip, input int gap_max);
    logic [7:0] sum;
    logic [7:0] bytes[$];
    sum = len_b;
    bytes = {};
    bytes.push_back(8'hA5);
    bytes.push_back(len_b);
    foreach (pl[i]) begin
      bytes.push_back(pl[i]);
      sum = sum ^ pl[i];
    end
    bytes.push_back(sum ^ flip);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat ($urandom_range(0, gap_max)) step();
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] pl[$]);
    check({tag, "/valid"}, 32'(o_frame_valid), 1);
    check({tag, "/len"}, 32'(o_frame_len), pl.size());
    foreach (pl[i]) begin
      i_rd_addr = 4'(i);
      step();
      check({tag, "/rd"}, 32'(o_rd_data), 32'(pl[i]));
    end
    i_frame_ack = 1'b1;
    step();
    i_frame_ack = 1'b0;
    check({tag, "/valid_after_ack"}, 32'(o_frame_valid), 0);
  endtask

  function automatic logic [7:0] rand_garbage();
    logic [7:0] g;
    g = 8'($urandom);
    if (g == 8'hA5) g = 8'h5A;
    return g;
  endfunction

  initial begin
    logic [7:0] pl[$];
    logic [7:0] empty[$];
    int kind;
    int n;
    empty = {};

    i_rst       = 1'b0;
    i_data      = 8'd0;
    i_ready     = 1'b0;
    i_rd_addr   = 4'd0;
    i_frame_ack = 1'b0;
    repeat (3) step();
    check("reset/valid", 32'(o_frame_valid), 0);
    check("reset/len", 32'(o_frame_len), 0);
    check("reset/rd_data", 32'(o_rd_data), 0);
    check_errs("reset", 0, 0, 0, 0);
    i_rst = 1'b1;
    step();

    pl = {8'h11, 8'h22, 8'h33};
    send_frame(8'd3, pl, 8'h00, 0);
    check_errs("good3", 0, 0, 0, 0);
    expect_frame("good3", pl);

    send_frame(8'd3, pl, 8'h07, 0);
    step();
    check("badchk/valid", 32'(o_frame_valid), 0);
    check_errs("badchk", 1, 0, 0, 0);
    pl = {8'h44, 8'h55};
    send_frame(8'd2, pl, 8'h00, 1);
    expect_frame("after_badchk", pl);
    check_errs("after_badchk", 0, 0, 0, 0);

    send_byte(8'h00);
    send_byte(8'hFF);
    check_errs("garbage", 0, 0, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    check_errs("len0", 0, 1, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h11);
    check_errs("len17", 0, 1, 0, 0);
    check("len17/valid", 32'(o_frame_valid), 0);

    pl = {};
    for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
    send_frame(8'(MAXL), pl, 8'h00, 0);
    expect_frame("maxlen", pl);
    pl = {8'h9C};
    send_frame(8'd1, pl, 8'h00, 0);
    expect_frame("len1", pl);
    check_errs("boundary_len", 0, 0, 0, 0);

    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    repeat (LIMIT - 1) step();
    check_errs("tmo_before_limit", 0, 0, 0, 0);
    step();
    check_errs("tmo_at_limit", 0, 0, 1, 0);
    check("tmo/valid", 32'(o_frame_valid), 0);
    step();
    check_errs("tmo_single_pulse", 0, 0, 0, 0);

    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    repeat (LIMIT - 1) step();
    send_byte(8'hBB);
    repeat (LIMIT - 1) step();
    check_errs("byte_wins_limit", 0, 0, 0, 0);
    send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
    pl = {8'hAA, 8'hBB};
    check_errs("late_frame", 0, 0, 0, 0);
    expect_frame("late_frame", pl);

    pl = {8'h5A, 8'hC3, 8'h0F};
    send_frame(8'd3, pl, 8'h00, 0);
    repeat (LIMIT + 20) step();
    check_errs("hold_no_timeout", 0, 0, 0, 0);
    send_byte(8'hA5);
    check_errs("overrun", 0, 0, 0, 1);
    send_byte(8'h01);
    check_errs("overrun2", 0, 0, 0, 1);
    expect_frame("held_unchanged", pl);

    pl = {8'h01, 8'h02};
    send_frame(8'd2, pl, 8'h00, 0);
    check("ack_and_byte/valid_before", 32'(o_frame_valid), 1);
    i_frame_ack = 1'b1;
    i_data      = 8'hA5;
    i_ready     = 1'b1;
    step();
    i_frame_ack = 1'b0;
    i_ready     = 1'b0;
    check("ack_and_byte/valid", 32'(o_frame_valid), 0);
    check_errs("ack_and_byte", 0, 0, 0, 1);
    send_byte(8'h03);
    send_byte(8'h04);
    check("ack_and_byte/dropped", 32'(o_frame_valid), 0);
    check_errs("ack_and_byte_dropped", 0, 0, 0, 0);

    i_frame_ack = 1'b1;
    step();
    i_frame_ack = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    i_frame_ack = 1'b1;
    step();
    i_frame_ack = 1'b0;
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30);
    pl = {8'h10, 8'h20, 8'h30};
    check_errs("ack_ignored", 0, 0, 0, 0);
    expect_frame("ack_ignored", pl);

    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    check("rst_mid/valid", 32'(o_frame_valid), 0);
    check("rst_mid/len", 32'(o_frame_len), 0);
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(8'd4, pl, 8'h00, 0);
    check_errs("rst_mid", 0, 0, 0, 0);
    expect_frame("rst_mid", pl);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) send_byte(rand_garbage());
      kind = int'($urandom_range(0, 3));
      if (kind == 3) begin
        send_byte(8'hA5);
        if ($urandom_range(0, 1) == 0) send_byte(8'h00);
        else send_byte(8'($urandom_range(MAXL + 1, 255)));
        check_errs("rnd_badlen", 0, 1, 0, 0);
      end else begin
        n = int'($urandom_range(1, MAXL));
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        if (kind == 2) begin
          send_frame(8'(n), pl, 8'($urandom_range(1, 255)), 3);
          check("rnd_badchk/valid", 32'(o_frame_valid), 0);
          check_errs("rnd_badchk", 1, 0, 0, 0);
        end else begin
          send_frame(8'(n), pl, 8'h00, 3);
          check_errs("rnd_good", 0, 0, 0, 0);
          expect_frame("rnd_good", pl);
        end
      end
    end
    if (empty.size() != 0) $display("queue not empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter input_clk_hz, default 12_000_000, input clock frequency.
REQ-002 SHALL have parameter baud_rate, default 9600, line rate used to derive the timeout.
REQ-003 SHALL have parameter max_len, default 16, maximum payload bytes per frame (power of two, 2..256).
REQ-004 SHALL have port i_clk  input  1  clock.
REQ-005 SHALL have port i_rst  input  1  reset: synchronous, active-low.
REQ-006 SHALL have port i_data  input  8  received byte from upstream UART receiver.
REQ-007 SHALL have port i_ready  input  1  one-cycle strobe marking i_data valid.
REQ-008 SHALL have port o_frame_valid  output  1  complete, checked frame held in buffer.
REQ-009 SHALL have port o_frame_len  output  $clog2(max_len)+1  payload length of held frame.
REQ-010 SHALL have port i_rd_addr  input  $clog2(max_len)  payload byte index to read.
REQ-011 SHALL have port o_rd_data  output  8  payload byte at i_rd_addr, registered.
REQ-012 SHALL have port i_frame_ack  input  1  consumer releases held frame.
REQ-013 SHALL have ports o_err_chk, o_err_len, o_err_timeout, o_err_overrun  output  1 each  one-cycle error pulses.

Function
REQ-014 Frame format SHALL be: SYNC 0xA5, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-015 FSM states SHALL be IDLE, LEN, PAYLOAD, CHK, HOLD; only i_ready cycles advance IDLE..CHK.
REQ-016 IDLE: byte 0xA5 -> LEN; any other byte discarded silently.
REQ-017 LEN: 1..max_len -> store length, init running XOR to LEN, reset byte index, -> PAYLOAD; 0 or >max_len -> o_err_len pulse, -> IDLE.
REQ-018 PAYLOAD: write byte to buffer[index], XOR into running sum, index+1; after LEN-th byte -> CHK.
REQ-019 CHK: byte == running XOR -> HOLD with o_frame_valid=1 from next cycle; mismatch -> o_err_chk pulse, -> IDLE.
REQ-020 HOLD: buffer write disabled; o_frame_len and buffer contents SHALL stay stable until ack.
REQ-021 HOLD: i_frame_ack -> IDLE, o_frame_valid low next cycle; i_frame_ack outside HOLD SHALL be ignored.
REQ-022 HOLD: any i_ready byte SHALL be dropped with o_err_overrun pulse, including 0xA5; same-cycle ack and byte -> byte dropped, overrun pulsed, ack honoured.
REQ-023 o_rd_data SHALL return buffer[i_rd_addr] one cycle after i_rd_addr is applied, in any state; addresses >= o_frame_len return stale contents, not an error.
REQ-024 Timeout limit SHALL be 20*(input_clk_hz/baud_rate) cycles (two byte times; 25000 at defaults); counter clears on every i_ready.
REQ-025 In LEN, PAYLOAD or CHK, counter reaching limit SHALL pulse o_err_timeout and -> IDLE; a byte arriving in the limit cycle SHALL win and no timeout fires.
REQ-026 Timeout counter SHALL not run in IDLE or HOLD; HOLD has no timeout.
REQ-027 Each error pulse SHALL be exactly one cycle, registered, at most one error per cycle.

Reset
REQ-028 i_rst=0 at rising i_clk SHALL force IDLE; clear o_frame_valid, o_frame_len, all error pulses, o_rd_data, index, XOR and timeout counter.
REQ-029 Reset mid-frame or in HOLD SHALL abandon the frame with no error pulse; buffer memory contents need not clear.

Structure
REQ-030 Shared package uart_pkg SHALL hold FSM state encodings, SYNC_BYTE = 8'hA5, and the divider/timeout calculation.
REQ-031 Payload storage SHALL be sub-module uart_frame_buf: max_len x 8, one synchronous write port, one registered read port.

Verification
REQ-032 A5 03 11 22 33 03 -> o_frame_valid=1, len=3; reads 0,1,2 -> 11,22,33; ack -> valid=0 next cycle.
REQ-033 A5 03 11 22 33 04 -> one o_err_chk pulse, valid stays 0; following good frame accepted.
REQ-034 A5 00, and A5 11 (17) -> o_err_len pulse each, back to IDLE; garbage 00 FF before A5 ignored, no error.
REQ-035 A5 02 AA then 25000 idle cycles -> o_err_timeout pulse at limit; byte at cycle 24999 -> no timeout.
REQ-036 While holding frame, send A5 -> o_err_overrun pulse, held data unchanged; ack and byte same cycle -> overrun plus release.
REQ-037 Reset asserted in PAYLOAD, then full good frame -> accepted, no error pulses.
